// File: rtl/s1_serial_tx.sv
// s1_serial_tx: reads the 18x8 bank RB1 into local flops, transposes it and
// ships each column as a 21-bit frame (3 address bits + 18 data bits, MSB
// first) over the sen/sd link to the S2 receiver.
module s1_serial_tx #(
    parameter int ROWS   = 18,
    parameter int COLS   = 8,
    parameter int AW_IN  = 5,
    parameter int AW_OUT = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              RB1_RW,
    output logic [AW_IN-1:0]  RB1_A,
    output logic [COLS-1:0]   RB1_D,
    input  logic [COLS-1:0]   RB1_Q,
    output logic              sen,
    output logic              sd,
    output logic              S1_done
);

    localparam int FW = ROWS + AW_OUT;   // frame width in bits
    localparam int CW = $clog2(FW);      // bit counter width

    typedef enum logic [2:0] {
        S_READ,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [AW_IN-1:0]            addr_q, addr_d;
    logic [AW_IN-1:0]            prev_addr_q, prev_addr_d;
    logic                        prev_vld_q, prev_vld_d;
    logic [ROWS-1:0][COLS-1:0]   row_buf_q, row_buf_d;
    logic [AW_OUT-1:0]           k_q, k_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        sen_q, sen_d;
    logic                        sd_q, sd_d;
    logic                        done_q, done_d;

    logic [ROWS-1:0]             col;
    logic [FW-1:0]               frame;

    // RB1 is only ever read
    assign RB1_RW  = 1'b1;
    assign RB1_D   = '0;
    assign RB1_A   = addr_q;
    assign sen     = sen_q;
    assign sd      = sd_q;
    assign S1_done = done_q;

    // Next-state, row capture, counters, and next-cycle link outputs
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        prev_addr_d = addr_q;
        prev_vld_d  = 1'b0;
        row_buf_d   = row_buf_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        col         = '0;
        frame       = '0;
        sen_d       = 1'b1;
        sd_d        = 1'b0;
        done_d      = 1'b0;

        // Read data lags the address by one cycle; store it under the
        // address that was presented last cycle.
        if (prev_vld_q) begin
            row_buf_d[prev_addr_q] = RB1_Q;
        end

        case (state_q)
            S_READ: begin
                prev_vld_d = 1'b1;
                if (addr_q == AW_IN'(ROWS - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    addr_d = addr_q + AW_IN'(1);
                end
            end
            S_LOAD: begin
                state_d = S_SEND;
                k_d     = '0;
                cnt_d   = CW'(FW - 1);
            end
            S_SEND: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (k_q == AW_OUT'(COLS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + AW_OUT'(1);
                    cnt_d   = CW'(FW - 1);
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_READ;
            end
        endcase

        // Outputs are registered: derive them from the state/counters the
        // next cycle will hold. The bit counter directly indexes the frame
        // {k, column k}, so cnt=20..18 selects k[2:0] and 17..0 the data.
        for (int j = 0; j < ROWS; j++) begin
            col[j] = row_buf_q[j][k_d];
        end
        frame = {k_d, col};
        if (state_d == S_SEND) begin
            sen_d = 1'b0;
            sd_d  = frame[cnt_d];
        end
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_READ;
            addr_q      <= '0;
            prev_addr_q <= '0;
            prev_vld_q  <= 1'b0;
            row_buf_q   <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            sen_q       <= 1'b1;
            sd_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            prev_addr_q <= prev_addr_d;
            prev_vld_q  <= prev_vld_d;
            row_buf_q   <= row_buf_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            sen_q       <= sen_d;
            sd_q        <= sd_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_s1_serial_tx.sv
// tb_s1_serial_tx: RB1 memory model, S2 receiver model and a cycle timeline
// reference derived from the frame rules; random and directed RB1 contents.
module tb_s1_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RB1_RW;
    logic [4:0]  RB1_A;
    logic [7:0]  RB1_D;
    logic [7:0]  RB1_Q = '0;
    logic        sen;
    logic        sd;
    logic        S1_done;

    logic [7:0]  mem [18];
    logic [17:0] rb2 [8];
    int          total = 0;
    int          bad   = 0;

    s1_serial_tx dut (
        .clk     (clk),
        .rst     (rst),
        .RB1_RW  (RB1_RW),
        .RB1_A   (RB1_A),
        .RB1_D   (RB1_D),
        .RB1_Q   (RB1_Q),
        .sen     (sen),
        .sd      (sd),
        .S1_done (S1_done)
    );

    always #5 clk = ~clk;

    // RB1: one-cycle synchronous read
    always @(posedge clk) RB1_Q <= (RB1_A < 5'd18) ? mem[RB1_A] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Hold reset 3 cycles, check reset values, release (returns in cycle 1)
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rw",   32'(RB1_RW),  32'd1);
        chk("rst_a",    32'(RB1_A),   32'd0);
        chk("rst_d",    32'(RB1_D),   32'd0);
        chk("rst_sen",  32'(sen),     32'd1);
        chk("rst_sd",   32'(sd),      32'd0);
        chk("rst_done", 32'(S1_done), 32'd0);
        rst = 1'b0;
    endtask

    // Column k of RB1 as an 18-bit word: bit j = row j bit k
    function automatic logic [17:0] col_word(input int k);
        logic [17:0] w;
        for (int j = 0; j < 18; j++) w[j] = mem[j][k];
        return w;
    endfunction

    // Walk the timeline from cycle 1; optionally assert reset in cycle stop_at
    task automatic run_seq(input int stop_at);
        logic [20:0] shreg;
        logic [20:0] frame;
        int          nb;
        int          p;
        int          k;
        logic        esen;
        logic        esd;
        shreg = '0;
        nb    = 0;
        for (int i = 0; i < 8; i++) rb2[i] = '0;
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge clk);
            esen = 1'b1;
            esd  = 1'b0;
            if (n >= 20 && n < 196) begin
                p = (n - 20) % 22;
                k = (n - 20) / 22;
                if (p <= 20) begin
                    esen  = 1'b0;
                    frame = {k[2:0], col_word(k)};
                    esd   = frame[20 - p];
                end
            end
            chk("addr", 32'(RB1_A), (n <= 18) ? 32'(n - 1) : 32'd17);
            chk("rw",   32'(RB1_RW),  32'd1);
            chk("sen",  32'(sen),     32'(esen));
            chk("sd",   32'(sd),      32'(esd));
            chk("done", 32'(S1_done), (n >= 196) ? 32'd1 : 32'd0);
            // S2 model: shift while sen low, commit on the first high cycle
            if (!sen) begin
                shreg = {shreg[19:0], sd};
                nb++;
            end else if (nb > 0) begin
                chk("s2_len", 32'(nb), 32'd21);
                rb2[shreg[20:18]] = shreg[17:0];
                nb = 0;
            end
            if (n == stop_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_sen",  32'(sen),     32'd1);
                chk("abort_sd",   32'(sd),      32'd0);
                chk("abort_a",    32'(RB1_A),   32'd0);
                chk("abort_done", 32'(S1_done), 32'd0);
                return;
            end
        end
        for (int i = 0; i < 8; i++) chk("rb2", 32'(rb2[i]), 32'(col_word(i)));
    endtask

    initial begin
        // all rows zero
        for (int j = 0; j < 18; j++) mem[j] = 8'h00;
        do_reset();
        run_seq(0);

        // row 17 = 80, others 0: only frame 7 carries data (MSB)
        mem[17] = 8'h80;
        do_reset();
        run_seq(0);
        chk("rb2_7_msb", 32'(rb2[7]), 32'h20000);

        // every row = 01
        for (int j = 0; j < 18; j++) mem[j] = 8'h01;
        do_reset();
        run_seq(0);
        chk("rb2_0_ones", 32'(rb2[0]), 32'h3FFFF);
        chk("rb2_1_zero", 32'(rb2[1]), 32'h0);

        // row j = j
        for (int j = 0; j < 18; j++) mem[j] = 8'(j);
        do_reset();
        run_seq(0);
        chk("rb2_0_idx", 32'(rb2[0]), 32'h2AAAA);
        chk("rb2_4_idx", 32'(rb2[4]), 32'h30000);
        chk("rb2_5_idx", 32'(rb2[5]), 32'h0);

        // random contents
        repeat (3) begin
            for (int j = 0; j < 18; j++) mem[j] = 8'($urandom);
            do_reset();
            run_seq(0);
        end

        // reset in cycle 10 of frame 3, then a full clean run
        for (int j = 0; j < 18; j++) mem[j] = 8'($urandom);
        do_reset();
        run_seq(20 + 3 * 22 + 9);
        do_reset();
        run_seq(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
